// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between I- and D-cache.
// Serialises transfers, routes responses back, aborts hung transfers.
module mem_arbiter #(
  parameter int              AW       = 32,
  parameter int              DW       = 32,
  parameter int              TIMEOUT  = 64,
  parameter logic [DW-1:0]   ERR_DATA = 32'hDEADBEEF
) (
  input  logic          CLK,
  input  logic          Reset,
  input  logic          iReq,
  input  logic [AW-1:0] iAddr,
  input  logic          iWE,
  input  logic [DW-1:0] iWD,
  output logic          iReady,
  output logic [DW-1:0] iRD,
  input  logic          dReq,
  input  logic [AW-1:0] dAddr,
  input  logic          dWE,
  input  logic [DW-1:0] dWD,
  output logic          dReady,
  output logic [DW-1:0] dRD,
  output logic          MReq,
  output logic [AW-1:0] MAddr,
  output logic          MWE,
  output logic [DW-1:0] MWD,
  input  logic          MReady,
  input  logic [DW-1:0] MRD,
  output logic          busy,
  output logic [1:0]    grant,
  output logic          err
);

  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY_I,
    S_BUSY_D,
    S_REL
  } state_t;

  state_t        r_state;
  state_t        w_state_n;

  // r_last: 1 = D-cache was served last
  logic          r_last;
  logic [TW-1:0] r_timer;
  logic          r_mreq;
  logic [AW-1:0] r_maddr;
  logic          r_mwe;
  logic [DW-1:0] r_mwd;
  logic [1:0]    r_grant;
  logic          r_err;
  logic          r_irdy;
  logic          r_drdy;
  logic [DW-1:0] r_ird;
  logic [DW-1:0] r_drd;

  logic          w_last_n;
  logic [TW-1:0] w_timer_n;
  logic          w_mreq_n;
  logic [AW-1:0] w_maddr_n;
  logic          w_mwe_n;
  logic [DW-1:0] w_mwd_n;
  logic [1:0]    w_grant_n;
  logic          w_err_n;
  logic          w_irdy_n;
  logic          w_drdy_n;
  logic [DW-1:0] w_ird_n;
  logic [DW-1:0] w_drd_n;
  logic          w_pick_i;
  logic          w_pick_d;
  logic          w_tmo;
  logic [DW-1:0] w_rdata;

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_n;
    end
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      r_last  <= 1'b1;
      r_timer <= '0;
      r_mreq  <= 1'b0;
      r_maddr <= '0;
      r_mwe   <= 1'b0;
      r_mwd   <= '0;
      r_grant <= 2'b00;
      r_err   <= 1'b0;
      r_irdy  <= 1'b0;
      r_drdy  <= 1'b0;
      r_ird   <= '0;
      r_drd   <= '0;
    end else begin
      r_last  <= w_last_n;
      r_timer <= w_timer_n;
      r_mreq  <= w_mreq_n;
      r_maddr <= w_maddr_n;
      r_mwe   <= w_mwe_n;
      r_mwd   <= w_mwd_n;
      r_grant <= w_grant_n;
      r_err   <= w_err_n;
      r_irdy  <= w_irdy_n;
      r_drdy  <= w_drdy_n;
      r_ird   <= w_ird_n;
      r_drd   <= w_drd_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_last_n  = r_last;
    w_timer_n = r_timer;
    w_mreq_n  = r_mreq;
    w_maddr_n = r_maddr;
    w_mwe_n   = r_mwe;
    w_mwd_n   = r_mwd;
    w_grant_n = r_grant;
    w_err_n   = r_err;
    w_irdy_n  = 1'b0;
    w_drdy_n  = 1'b0;
    w_ird_n   = r_ird;
    w_drd_n   = r_drd;
    w_pick_i  = iReq & (~dReq | r_last);
    w_pick_d  = dReq & (~iReq | ~r_last);
    w_tmo     = (r_timer == TLAST);
    w_rdata   = MReady ? MRD : ERR_DATA;

    unique case (r_state)
      S_IDLE: begin
        unique case (1'b1)
          w_pick_i: begin
            w_state_n = S_BUSY_I;
            w_maddr_n = iAddr;
            w_mwe_n   = iWE;
            w_mwd_n   = iWD;
            w_mreq_n  = 1'b1;
            w_grant_n = 2'b01;
            w_timer_n = '0;
          end
          w_pick_d: begin
            w_state_n = S_BUSY_D;
            w_maddr_n = dAddr;
            w_mwe_n   = dWE;
            w_mwd_n   = dWD;
            w_mreq_n  = 1'b1;
            w_grant_n = 2'b10;
            w_timer_n = '0;
          end
          default: ;
        endcase
      end
      S_BUSY_I, S_BUSY_D: begin
        if (MReady || w_tmo) begin
          w_state_n = S_REL;
          w_mreq_n  = 1'b0;
          w_grant_n = 2'b00;
          if (!MReady) begin
            w_err_n = 1'b1;
          end
          if (r_state == S_BUSY_I) begin
            w_last_n = 1'b0;
            w_ird_n  = w_rdata;
            w_irdy_n = 1'b1;
          end else begin
            w_last_n = 1'b1;
            w_drd_n  = w_rdata;
            w_drdy_n = 1'b1;
          end
        end else begin
          w_timer_n = r_timer + TW'(1);
        end
      end
      // one dead cycle so the finishing client's Req is not re-granted
      S_REL: begin
        w_state_n = S_IDLE;
      end
      default: begin
        w_state_n = S_IDLE;
      end
    endcase
  end

  assign MReq   = r_mreq;
  assign MAddr  = r_maddr;
  assign MWE    = r_mwe;
  assign MWD    = r_mwd;
  assign grant  = r_grant;
  assign err    = r_err;
  assign iReady = r_irdy;
  assign dReady = r_drdy;
  assign iRD    = r_ird;
  assign dRD    = r_drd;
  assign busy   = (r_state != S_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: vector table plus hand sequences
// for reset, fairness, timeout and stray MReady.
module tb_mem_arbiter;

  logic        CLK;
  logic        Reset;
  logic        iReq;
  logic [31:0] iAddr;
  logic        iWE;
  logic [31:0] iWD;
  logic        iReady;
  logic [31:0] iRD;
  logic        dReq;
  logic [31:0] dAddr;
  logic        dWE;
  logic [31:0] dWD;
  logic        dReady;
  logic [31:0] dRD;
  logic        MReq;
  logic [31:0] MAddr;
  logic        MWE;
  logic [31:0] MWD;
  logic        MReady;
  logic [31:0] MRD;
  logic        busy;
  logic [1:0]  grant;
  logic        err;

  int n_chk;
  int n_fail;

  mem_arbiter #(
    .AW(32), .DW(32), .TIMEOUT(64), .ERR_DATA(32'hDEADBEEF)
  ) dut (
    .CLK(CLK), .Reset(Reset),
    .iReq(iReq), .iAddr(iAddr), .iWE(iWE), .iWD(iWD),
    .iReady(iReady), .iRD(iRD),
    .dReq(dReq), .dAddr(dAddr), .dWE(dWE), .dWD(dWD),
    .dReady(dReady), .dRD(dRD),
    .MReq(MReq), .MAddr(MAddr), .MWE(MWE), .MWD(MWD),
    .MReady(MReady), .MRD(MRD),
    .busy(busy), .grant(grant), .err(err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        sel_d;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wd;
    int          lat;
    logic [31:0] mrd;
    logic [1:0]  e_grant;
    int          e_cyc;
    logic [31:0] e_rd;
  } vec_t;

  vec_t vt [4];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_grant(output logic ok);
    ok = 1'b0;
    for (int g = 0; g < 8; g++) begin
      tick();
      if (grant != 2'b00) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  always @(negedge CLK) begin
    if (iReady && dReady) begin
      n_chk++;
      n_fail++;
      $display("FAIL both_ready: got 11 expected not 11");
    end
    if (grant == 2'b11) begin
      n_chk++;
      n_fail++;
      $display("FAIL grant_11: got %b expected one-hot", grant);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ok;
    int   cyc;
    logic [1:0] exp_g [4];
    n_chk  = 0;
    n_fail = 0;

    vt[0] = '{1'b0, 32'h40, 1'b0, 32'h0, 2, 32'h2402000A,
              2'b01, 3, 32'h2402000A};
    vt[1] = '{1'b1, 32'h100, 1'b1, 32'h55, 0, 32'h12345678,
              2'b10, 1, 32'h12345678};
    vt[2] = '{1'b1, 32'h200, 1'b0, 32'h0, 4, 32'hCAFEF00D,
              2'b10, 5, 32'hCAFEF00D};
    vt[3] = '{1'b0, 32'hFFFFFFFC, 1'b1, 32'hA5A5A5A5, 1, 32'h0,
              2'b01, 2, 32'h0};
    exp_g[0] = 2'b01;
    exp_g[1] = 2'b10;
    exp_g[2] = 2'b01;
    exp_g[3] = 2'b10;

    Reset = 1'b0;
    iReq = 0; iAddr = 0; iWE = 0; iWD = 0;
    dReq = 0; dAddr = 0; dWE = 0; dWD = 0;
    MReady = 0; MRD = 0;
    tick(); tick();
    Reset = 1'b1;
    tick();
    chk("rst_mreq", 32'(MReq), 32'h0);
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_rdy", 32'({iReady, dReady}), 32'h0);
    chk("rst_ird", iRD, 32'h0);
    chk("rst_drd", dRD, 32'h0);
    chk("rst_maddr", MAddr, 32'h0);

    for (int k = 0; k < 4; k++) begin
      if (vt[k].sel_d) begin
        dReq = 1; dAddr = vt[k].addr; dWE = vt[k].we; dWD = vt[k].wd;
      end else begin
        iReq = 1; iAddr = vt[k].addr; iWE = vt[k].we; iWD = vt[k].wd;
      end
      tick();
      chk("v_grant", 32'(grant), 32'(vt[k].e_grant));
      chk("v_mreq", 32'(MReq), 32'h1);
      chk("v_maddr", MAddr, vt[k].addr);
      chk("v_mwe", 32'(MWE), 32'(vt[k].we));
      chk("v_mwd", MWD, vt[k].wd);
      chk("v_busy", 32'(busy), 32'h1);
      cyc = 1;
      for (int j = 0; j < vt[k].lat; j++) begin
        tick();
        if (MReq) cyc++;
      end
      MReady = 1; MRD = vt[k].mrd;
      tick();
      MReady = 0; MRD = 0;
      chk("v_mreq_cyc", 32'(cyc), 32'(vt[k].e_cyc));
      chk("v_ready", 32'({dReady, iReady}), 32'(vt[k].e_grant));
      chk("v_rd", vt[k].sel_d ? dRD : iRD, vt[k].e_rd);
      chk("v_mreq_off", 32'(MReq), 32'h0);
      chk("v_grant_off", 32'(grant), 32'h0);
      chk("v_busy_rel", 32'(busy), 32'h1);
      tick();
      chk("v_no_regrant", 32'(grant), 32'h0);
      chk("v_idle", 32'(busy), 32'h0);
      chk("v_ready_off", 32'({dReady, iReady}), 32'h0);
      iReq = 0; dReq = 0;
    end

    dReq = 1; dAddr = 32'h100; dWE = 1; dWD = 32'h55;
    tick();
    chk("a_grant_d", 32'(grant), 32'h2);
    tick(); tick();
    Reset = 1'b0;
    #1;
    chk("a_rst_mreq", 32'(MReq), 32'h0);
    chk("a_rst_grant", 32'(grant), 32'h0);
    chk("a_rst_drdy", 32'(dReady), 32'h0);
    chk("a_rst_busy", 32'(busy), 32'h0);
    tick();
    Reset = 1'b1;
    iReq = 1; iAddr = 32'h80; iWE = 0; iWD = 0;
    for (int t = 0; t < 4; t++) begin
      wait_grant(ok);
      chk("b_grant_seen", 32'(ok), 32'h1);
      chk("b_grant", 32'(grant), 32'(exp_g[t]));
      if (exp_g[t] == 2'b10) begin
        chk("b_maddr", MAddr, 32'h100);
        chk("b_mwe", 32'(MWE), 32'h1);
        chk("b_mwd", MWD, 32'h55);
      end else begin
        chk("b_maddr_i", MAddr, 32'h80);
        chk("b_mwe_i", 32'(MWE), 32'h0);
      end
      MReady = 1; MRD = 32'h1000 + t;
      tick();
      MReady = 0;
      chk("b_ready", 32'({dReady, iReady}), 32'(exp_g[t]));
    end
    iReq = 0; dReq = 0;
    tick();

    dReq = 1; dAddr = 32'h300; dWE = 0;
    tick();
    chk("c_grant_d", 32'(grant), 32'h2);
    iReq = 1; iAddr = 32'h80;
    tick();
    MReady = 1; MRD = 32'hABCD;
    tick();
    MReady = 0;
    chk("c_drdy", 32'(dReady), 32'h1);
    chk("c_drd", dRD, 32'hABCD);
    tick();
    tick();
    chk("c_grant_i", 32'(grant), 32'h1);
    MReady = 1; MRD = 32'h1234;
    tick();
    MReady = 0;
    chk("c_irdy", 32'(iReady), 32'h1);
    chk("c_ird", iRD, 32'h1234);
    iReq = 0; dReq = 0;
    tick();

    iReq = 1; iAddr = 32'h44; iWE = 0;
    tick();
    cyc = (grant == 2'b01) ? 1 : 0;
    for (int g = 0; g < 100 && !iReady; g++) begin
      tick();
      if (grant == 2'b01) cyc++;
    end
    chk("d_busy_cyc", 32'(cyc), 32'd64);
    chk("d_irdy", 32'(iReady), 32'h1);
    chk("d_ird_err", iRD, 32'hDEADBEEF);
    chk("d_err", 32'(err), 32'h1);
    tick();
    iReq = 0;
    dReq = 1; dAddr = 32'h500; dWE = 0;
    tick();
    chk("d_grant_after", 32'(grant), 32'h2);
    MReady = 1; MRD = 32'h1111;
    tick();
    MReady = 0;
    chk("d_drdy_norm", 32'(dReady), 32'h1);
    chk("d_drd_norm", dRD, 32'h1111);
    tick();
    dReq = 0;
    chk("d_err_sticky", 32'(err), 32'h1);

    MReady = 1; MRD = 32'h999;
    for (int g = 0; g < 3; g++) begin
      tick();
      chk("e_idle_rdy", 32'({dReady, iReady}), 32'h0);
      chk("e_idle_busy", 32'(busy), 32'h0);
    end
    chk("e_ird_keep", iRD, 32'hDEADBEEF);
    chk("e_drd_keep", dRD, 32'h1111);
    MReady = 0;
    iReq = 1; iAddr = 32'h60;
    tick();
    MReady = 1; MRD = 32'h77;
    tick();
    chk("e_ird", iRD, 32'h77);
    MRD = 32'h888;
    tick();
    iReq = 0;
    chk("e_rel_ird", iRD, 32'h77);
    chk("e_rel_rdy", 32'({dReady, iReady}), 32'h0);
    chk("e_rel_busy", 32'(busy), 32'h0);
    chk("e_rel_grant", 32'(grant), 32'h0);
    tick();
    MReady = 0;
    chk("e_final_grant", 32'(grant), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
